inv_sub_bytes_seq: RTL



---
 rtl/inv_sub_bytes_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES-128 InvSubBytes engine.
// A 128-bit state is accepted in IDLE, substituted BYTES_PER_CYCLE bytes per
// cycle in BUSY, and presented on out_state in DONE until it is taken.
// Byte 0 of the state is bits [127:120]; byte 15 is bits [7:0].
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCYC = 16 / BYTES_PER_CYCLE;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int SW   = 8 * BYTES_PER_CYCLE;

    // Handshake: a transfer occurs on a rising edge where valid and ready are
    // both high; in_valid is only looked at in IDLE, out_ready only in DONE.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [0:NCYC-1][SW-1:0] work_q, work_d;   // element 0 holds byte 0 side
    logic [127:0]            out_q, out_d;
    logic [SW-1:0]           slice_in;
    logic [SW-1:0]           slice_sub;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero naturally maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: inverse affine map (bit i = x[i+2]^x[i+5]^x[i+7]^c[i],
    // c = 0x05) expressed as rotations, followed by the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    assign slice_in = work_q[cnt_q];

    // Substitute the slice selected by the counter with parallel lookups.
    always_comb begin
        slice_sub = '0;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            slice_sub[j*8 +: 8] = inv_sbox(slice_in[j*8 +: 8]);
        end
    end

    // Next-state logic: accept, substitute slice by slice, hold until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d[cnt_q] = slice_sub;
                if (cnt_q == CW'(NCYC - 1)) begin
                    out_d   = work_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = out_q;

endmodule
